// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller.
// Flag vectors are ordered {c, z, o, s}, matching the ALU output.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } ctrl_state_t;

  localparam int ALU_FLAGS_W = 4;
  localparam int FLG_C       = 3;
  localparam int FLG_Z       = 2;
  localparam int FLG_O       = 1;
  localparam int FLG_S       = 0;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at its own pointer, and the pointer
// moves past the winner only when the owner signals that the grant was taken.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant_onehot,
  output logic [IDW-1:0] grant_idx
);

  logic [IDW-1:0] ptr_r;

  // Pick the first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    logic found_v;
    logic hit_v;
    int   idx_v;
    grant_onehot = '0;
    grant_idx    = '0;
    found_v      = 1'b0;
    hit_v        = 1'b0;
    idx_v        = 0;
    for (int i = 0; i < N; i++) begin
      idx_v               = (int'(ptr_r) + i) % N;
      hit_v               = req[idx_v] && !found_v;
      grant_onehot[idx_v] = hit_v;
      grant_idx           = hit_v ? IDW'(idx_v) : grant_idx;
      found_v             = found_v | hit_v;
    end
  end

  // Pointer update: only an accepted grant moves it, to the slot after the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU among NREQ requesters: one op in flight,
// operands held in registers, and the result returned with the requester id.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int DWIDTH = 128,
  parameter  int NREQ   = 4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_op1,
  input  logic [NREQ*DWIDTH-1:0] req_op2,
  input  logic [NREQ*3-1:0]      req_opsel,
  input  logic [NREQ-1:0]        req_mode,
  output logic [DWIDTH-1:0]      alu_op1,
  output logic [DWIDTH-1:0]      alu_op2,
  output logic [2:0]             alu_opsel,
  output logic                   alu_mode,
  input  logic [DWIDTH-1:0]      alu_result,
  input  logic [ALU_FLAGS_W-1:0] alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DWIDTH-1:0]      rsp_result,
  output logic [ALU_FLAGS_W-1:0] rsp_flags,
  output logic                   busy
);

  ctrl_state_t            state_r;
  logic [DWIDTH-1:0]      op1_r;
  logic [DWIDTH-1:0]      op2_r;
  logic [2:0]             opsel_r;
  logic                   mode_r;
  logic [IDW-1:0]         id_r;
  logic                   rsp_valid_r;
  logic [IDW-1:0]         rsp_id_r;
  logic [DWIDTH-1:0]      rsp_result_r;
  logic [ALU_FLAGS_W-1:0] rsp_flags_r;
  logic [NREQ-1:0]        grant_onehot_s;
  logic [IDW-1:0]         grant_idx_s;
  logic                   accept_s;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req_valid),
    .advance      (accept_s),
    .grant_onehot (grant_onehot_s),
    .grant_idx    (grant_idx_s)
  );

  // Grants are only offered while idle; reset masks them so nothing is accepted.
  always_comb begin
    if ((state_r == S_IDLE) && !rst) begin
      req_ready = grant_onehot_s;
      accept_s  = |req_valid;
    end else begin
      req_ready = '0;
      accept_s  = 1'b0;
    end
  end

  // Controller FSM: capture on handshake, sample the ALU in EXEC, hold the response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op1_r        <= '0;
      op2_r        <= '0;
      opsel_r      <= 3'd0;
      mode_r       <= 1'b0;
      id_r         <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= '0;
      rsp_flags_r  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op1_r   <= req_op1[int'(grant_idx_s)*DWIDTH +: DWIDTH];
            op2_r   <= req_op2[int'(grant_idx_s)*DWIDTH +: DWIDTH];
            opsel_r <= req_opsel[int'(grant_idx_s)*3 +: 3];
            mode_r  <= req_mode[grant_idx_s];
            id_r    <= grant_idx_s;
            state_r <= S_EXEC;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          rsp_result_r <= alu_result;
          rsp_flags_r  <= alu_flags;
          rsp_id_r     <= id_r;
          rsp_valid_r  <= 1'b1;
          state_r      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            state_r     <= S_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_op1    = op1_r;
  assign alu_op2    = op2_r;
  assign alu_opsel  = opsel_r;
  assign alu_mode   = mode_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;
  assign busy       = (state_r != S_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with an adder stub as the ALU
// (result = op1 + op2, flags = {opsel, mode}); responses go through a scoreboard.
module tb_alu_share_ctrl;
  localparam int DW  = 128;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_op1;
  logic [NR*DW-1:0]  req_op2;
  logic [NR*3-1:0]   req_opsel;
  logic [NR-1:0]     req_mode;
  logic [DW-1:0]     alu_op1;
  logic [DW-1:0]     alu_op2;
  logic [2:0]        alu_opsel;
  logic              alu_mode;
  logic [DW-1:0]     alu_result;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_result;
  logic [3:0]        rsp_flags;
  logic              busy;

  logic [DW-1:0] op1_a   [NR];
  logic [DW-1:0] op2_a   [NR];
  logic [2:0]    opsel_a [NR];
  logic          mode_a  [NR];

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  result;
    logic [3:0]     flags;
  } exp_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  op1;
    logic [DW-1:0]  op2;
    logic [2:0]     opsel;
    logic           mode;
    logic [DW-1:0]  exp_result;
    logic [3:0]     exp_flags;
  } vec_t;

  exp_t sb[$];
  int   grant_idx_log[$];
  int   grant_cyc_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   gi;

  alu_share_ctrl #(.DWIDTH(DW), .NREQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opsel  (req_opsel),
    .req_mode   (req_mode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign alu_result = alu_op1 + alu_op2;
  assign alu_flags  = {alu_opsel, alu_mode};

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      req_op1[k*DW +: DW] = op1_a[k];
      req_op2[k*DW +: DW] = op2_a[k];
      req_opsel[k*3 +: 3] = opsel_a[k];
      req_mode[k]         = mode_a[k];
    end
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant logger and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && (req_ready != '0)) begin
      chk("ready_onehot", $countones(req_ready), 1);
      gi = -1;
      for (int k = 0; k < NR; k++) if (req_ready[k]) gi = k;
      grant_idx_log.push_back(gi);
      grant_cyc_log.push_back(cyc_cnt);
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.result);
        chk("rsp_flags", rsp_flags, e.flags);
      end
    end
  end

  task automatic wait_grant(input int id, input string name);
    int k;
    k = 0;
    #1;
    while (!req_ready[id] && k < 20) begin
      cyc();
      #1;
      k++;
    end
    chk(name, req_ready[id], 1);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      cyc();
      k++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    vec_t tbl[4];
    int   exp_order[5];
    int   k;
    tbl[0] = '{id: 2'd2, op1: 128'd5, op2: 128'd7, opsel: 3'b010, mode: 1'b1,
               exp_result: 128'd12, exp_flags: 4'b0101};
    tbl[1] = '{id: 2'd1, op1: 128'hffffffff_ffffffff_ffffffff_ffffffff, op2: 128'd1,
               opsel: 3'b111, mode: 1'b0, exp_result: 128'd0, exp_flags: 4'b1110};
    tbl[2] = '{id: 2'd3, op1: 128'h00000000_00000001_00000000_00000000,
               op2: 128'h00000000_00000001_00000000_00000000, opsel: 3'b100, mode: 1'b1,
               exp_result: 128'h00000000_00000002_00000000_00000000, exp_flags: 4'b1001};
    tbl[3] = '{id: 2'd0, op1: 128'h80000000_00000000_00000000_00000001, op2: 128'd2,
               opsel: 3'b011, mode: 1'b0,
               exp_result: 128'h80000000_00000000_00000000_00000003, exp_flags: 4'b0110};
    exp_order = '{0, 1, 2, 3, 0};

    for (int i = 0; i < NR; i++) begin
      op1_a[i]   = DW'(i * 100 + 1);
      op2_a[i]   = DW'(i + 10);
      opsel_a[i] = 3'(i);
      mode_a[i]  = i[0];
    end
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;

    // Reset held with every requester asking.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_op1", alu_op1, 0);
    end

    // Round robin with everyone valid and the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.id     = IDW'(exp_order[i]);
      e.result = DW'(exp_order[i] * 100 + 1) + DW'(exp_order[i] + 10);
      e.flags  = {3'(exp_order[i]), exp_order[i][0]};
      sb.push_back(e);
    end
    rst = 1'b0;
    #1;
    chk("first_grant_after_rst", req_ready, 4'b0001);
    k = 0;
    while (grant_idx_log.size() < 5 && k < 40) begin
      cyc();
      k++;
    end
    req_valid = '0;
    chk("rr_grant_count", grant_idx_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_idx_log.size(); i++) begin
      chk("rr_grant_order", grant_idx_log[i], exp_order[i]);
      if (i > 0) chk("rr_grant_spacing", grant_cyc_log[i] - grant_cyc_log[i-1], 3);
    end
    wait_drain("rr_drain");
    cyc();

    // Table of single ops, each checked for latency and result.
    for (int t = 0; t < 4; t++) begin
      op1_a[tbl[t].id]   = tbl[t].op1;
      op2_a[tbl[t].id]   = tbl[t].op2;
      opsel_a[tbl[t].id] = tbl[t].opsel;
      mode_a[tbl[t].id]  = tbl[t].mode;
      req_valid[tbl[t].id] = 1'b1;
      sb.push_back('{id: tbl[t].id, result: tbl[t].exp_result, flags: tbl[t].exp_flags});
      wait_grant(int'(tbl[t].id), "tbl_grant");
      cyc();
      req_valid = '0;
      chk("tbl_exec_no_rsp", rsp_valid, 0);
      chk("tbl_exec_busy", busy, 1);
      cyc();
      chk("tbl_rsp_latency", rsp_valid, 1);
      cyc();
      chk("tbl_rsp_popped", sb.size(), 0);
      chk("tbl_idle", busy, 0);
    end

    // Back-pressure: response held, other requester kept waiting.
    rsp_ready = 1'b0;
    op1_a[1] = 128'd100; op2_a[1] = 128'd23; opsel_a[1] = 3'b001; mode_a[1] = 1'b0;
    op1_a[3] = 128'd40;  op2_a[3] = 128'd2;  opsel_a[3] = 3'b110; mode_a[3] = 1'b1;
    sb.push_back('{id: 2'd1, result: 128'd123, flags: 4'b0010});
    sb.push_back('{id: 2'd3, result: 128'd42, flags: 4'b1101});
    req_valid = 4'b1010;
    #1;
    chk("bp_first_grant", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_rsp_result", rsp_result, 123);
      chk("bp_rsp_flags", rsp_flags, 4'b0010);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    #1;
    chk("bp_next_grant", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    wait_drain("bp_drain");

    // Reset while a response is pending: op dropped, pointer back to 0.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("rr_grant2", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    cyc();
    chk("resp_before_rst", rsp_valid, 1);
    rst = 1'b1;
    cyc();
    chk("rst_in_resp_valid", rsp_valid, 0);
    chk("rst_in_resp_busy", busy, 0);
    chk("rst_in_resp_result", rsp_result, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("no_rsp_after_rst", rsp_valid, 0);
    sb.push_back('{id: 2'd1, result: 128'd123, flags: 4'b0010});
    req_valid = 4'b1010;
    #1;
    chk("ptr_reset_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    wait_drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
